// File: rtl/g1_sched.sv
// g1_sched: round-robin scheduler that time-shares one combinational g1
// encoder among four requesters. A granted operand is held on g1_x for
// SETTLE cycles, then g1_y is captured and returned with a one-cycle ack.
module g1_sched #(
    parameter int SETTLE = 2  // cycles g1_x is held before g1_y is sampled (1..15)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] din,
    output logic [3:0]  g1_x,
    input  logic [1:0]  g1_y,
    output logic [3:0]  ack,
    output logic [1:0]  result,
    output logic [1:0]  result_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;        // remaining DRIVE cycles minus one
    logic [3:0]  operand;    // operand latched at grant
    logic [1:0]  last;       // most recently granted requester
    logic [1:0]  win;        // arbitration winner this cycle
    logic        win_vld;    // some requester is asking

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        win     = last;
        win_vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!win_vld && req[last + 2'(i)]) begin
                win     = last + 2'(i);
                win_vld = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-derived outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        g1_x      = (state == IDLE) ? 4'd0 : operand;
        case (state)
            IDLE:    if (win_vld)    state_nxt = DRIVE;
            DRIVE:   if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: grant capture, settle counter, result capture and ack pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            operand   <= 4'd0;
            last      <= 2'd3;
            ack       <= 4'd0;
            result    <= 2'd0;
            result_id <= 2'd0;
        end else begin
            ack <= 4'd0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        operand <= din[{win, 2'b00} +: 4];
                        last    <= win;
                        cnt     <= 4'(SETTLE - 1);
                    end
                end
                DRIVE: begin
                    if (cnt == 4'd0) begin
                        result    <= g1_y;
                        result_id <= last;
                        ack       <= 4'd1 << last;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/g1_sched.md
# g1_sched

Round-robin scheduler that shares one combinational g1 encoder (4-bit `x` in, 2-bit `y` out, either the `g1_dataflow` or `g1_gate` implementation) among four requesters. A requester presents a 4-bit operand and holds a request. The scheduler grants one requester at a time and latches its operand onto the shared g1 input. It waits a programmable settle time, captures the 2-bit result, and returns it with a one-cycle acknowledge. It sits between the requesting logic and the single g1 instance, so g1 does not have to be replicated.

## Interface
- `SETTLE`, default 2: number of cycles g1_x is held stable before g1_y is sampled. Legal range 1..15.
- `clk` input, 1: system clock. All state changes on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `req` input, 4: level request, bit k for requester k.
- `din` input, 16: operands. Requester k drives `din[4k+3:4k]`.
- `g1_x` output, 4: operand driven to the shared g1 `x` port.
- `g1_y` input, 2: result from the shared g1 `y` port.
- `ack` output, 4: one-hot, one-cycle pulse. Bit k means requester k's result is valid.
- `result` output, 2: captured g1 result. Holds its value until the next ack.
- `result_id` output, 2: index of the requester that owns `result`.
- `busy` output, 1: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, DRIVE, RESP.
- IDLE:
  - `g1_x` = 0.
  - If `req` != 0, select the winner k (see arbitration below) and latch `din[4k+3:4k]` into the operand register.
  - Set the counter to SETTLE-1 and go to DRIVE. Otherwise stay in IDLE.
- Arbitration:
  - Pointer `last` holds the index of the most recently served requester.
  - The winner is the first requester with `req` set, searching `last+1`, `last+2`, … modulo 4.
  - `last` is updated at grant.
  - Reset value of `last` = 3, so requester 0 has first priority out of reset.
- DRIVE:
  - `g1_x` = latched operand.
  - The counter decrements each cycle.
  - On the edge where the counter == 0: `result` <= `g1_y`, `result_id` <= k, `ack[k]` <= 1, go to RESP.
- RESP:
  - `ack[k]` is high for exactly this cycle and `g1_x` still holds the operand.
  - Next state is always IDLE, and `ack` returns to 0.
- Operand capture: `din` and `req` are sampled only in IDLE. Changes to either during DRIVE or RESP are ignored. Dropping `req` mid-operation does not cancel the operation; the ack is still issued.
- A requester that keeps `req` high after its ack is treated as a new request. It is served again only after every other pending requester has been served once.
- Counter: 4 bits wide. SETTLE=1 means exactly one DRIVE cycle.
- Reset values: `g1_x`=0, `ack`=0, `result`=0, `result_id`=0, `busy`=0, state=IDLE, `last`=3.
- Reset asserted mid-operation aborts the operation. No ack is issued, and all outputs take their reset values on the next edge.

## Timing
- Request sampled at edge E0:
  - DRIVE occupies cycles E0..E0+SETTLE.
  - `ack`/`result` become valid after edge E0+SETTLE and stay valid for one cycle.
  - IDLE follows after edge E0+SETTLE+1.
- Grant-to-ack latency is SETTLE cycles. Each operation occupies SETTLE+2 cycles including IDLE.
- With all four requests held continuously, grants follow the order 0,1,2,3,0,… and one ack is issued every SETTLE+2 cycles.
- `g1_x` is stable for at least SETTLE full cycles before `g1_y` is sampled. g1 is combinational, so no further settling constraint applies.
- `result`/`result_id` are stable from the ack cycle until the next ack.

## Test plan
- Reset: hold `rst` 2 cycles with random `req`/`din`. Required: `g1_x`=0, `ack`=0, `result`=0, `busy`=0. No grant occurs while `rst` is high.
- Single request: SETTLE=2, `req`=4'b0100, `din[11:8]`=4'b1011. Required:
  - `g1_x`=4'b1011 for the 2 DRIVE cycles and the RESP cycle.
  - `ack`=4'b0100 for 1 cycle, 2 cycles after the grant edge.
  - `result` equals `g1_y` for x=4'b1011.
  - `result_id`=2.
- Round robin: `req`=4'b1111 held, operands 4'b0000/4'b1011/4'b0101/4'b1110. Required:
  - `ack` order 0,1,2,3,0.
  - Each `result` matches the g1 output for its operand.
  - Acks are spaced SETTLE+2 cycles apart.
- Fairness after reset: `req`=4'b1001 held. Required: acks alternate 0,3,0,3. Requester 0 is served first.
- Mid-operation changes: change `din` and drop `req` during DRIVE. Required: `g1_x` keeps the latched operand and the ack is still issued with the original result.
- Reset mid-DRIVE: assert `rst` for 1 cycle during DRIVE. Required: no ack is issued, outputs return to their reset values, and the next grant goes to requester 0 if it is requesting.
